// File: rtl/reg_bank_pkg.sv
// Shared write-mode encoding and index-width helper for the reg_bank_sel register bank.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    WR_FULL = 2'b00,
    WR_LO   = 2'b01,
    WR_HI   = 2'b10,
    WR_NOP  = 2'b11
  } wr_mode_e;

  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_read_mux.sv
// Combinational NUM_REGS:1 word selector; in_range flags indices that name a real register.
module reg_bank_read_mux
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  logic [SEL_W-1:0]                sel,
  output logic [DATA_W-1:0]               data,
  output logic                            in_range
);

  // Non-power-of-two depths leave unused codes; those fall through to zero.
  always_comb begin
    data     = '0;
    in_range = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(sel) == i) begin
        data     = regs[i];
        in_range = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bank_sel.sv
// Register bank with one byte-lane write port and two registered read ports.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_BANK_BYPASS_EN.
module reg_bank_sel
  import reg_bank_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int               SEL_W     = sel_width(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [1:0]        wr_mode,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel_a,
  input  logic [SEL_W-1:0]  rd_sel_b,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              sel_err
);

  localparam int HALF_W = DATA_W / 2;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic                            rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]               rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0]               rd_data_b_q, rd_data_b_d;
  logic                            sel_err_q, sel_err_d;

  logic                            wr_in_range, wr_hit;
  logic [DATA_W-1:0]               mux_a, mux_b, word_a, word_b;
  logic                            in_range_a, in_range_b;

  // Half modes always take the new byte from the low lane of the write data.
  function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_word,
                                                   input logic [DATA_W-1:0] new_data,
                                                   input logic [1:0]        mode);
    case (wr_mode_e'(mode))
      WR_FULL: return new_data;
      WR_LO:   return {old_word[DATA_W-1:HALF_W], new_data[HALF_W-1:0]};
      WR_HI:   return {new_data[HALF_W-1:0], old_word[HALF_W-1:0]};
      default: return old_word;
    endcase
  endfunction

  assign wr_in_range = int'(wr_sel) < NUM_REGS;
  assign wr_hit      = wr_en && (wr_mode_e'(wr_mode) != WR_NOP) && wr_in_range;

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_hit && int'(wr_sel) == i) begin
        regs_d[i] = merge_word(regs_q[i], wr_data, wr_mode);
      end
    end
  end

  reg_bank_read_mux #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_mux_a (
    .regs     (regs_q),
    .sel      (rd_sel_a),
    .data     (mux_a),
    .in_range (in_range_a)
  );

  reg_bank_read_mux #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_mux_b (
    .regs     (regs_q),
    .sel      (rd_sel_b),
    .data     (mux_b),
    .in_range (in_range_b)
  );

  always_comb begin
    word_a = mux_a;
    word_b = mux_b;
`ifdef REG_BANK_BYPASS_EN
    if (wr_hit && wr_sel == rd_sel_a) word_a = merge_word(mux_a, wr_data, wr_mode);
    if (wr_hit && wr_sel == rd_sel_b) word_b = merge_word(mux_b, wr_data, wr_mode);
`endif
  end

  // Idle cycles hold the last read data; only the valid pulse drops.
  always_comb begin
    rd_valid_d  = rd_req;
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (rd_req) begin
      rd_data_a_d = in_range_a ? word_a : '0;
      rd_data_b_d = in_range_b ? word_b : '0;
    end
    sel_err_d = sel_err_q
              | (wr_en && !wr_in_range)
              | (rd_req && !(in_range_a && in_range_b));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q      <= {NUM_REGS{RESET_VAL}};
      rd_valid_q  <= 1'b0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_reg_bank_sel.sv
// Directed self-checking bench for reg_bank_sel: a 16-deep instance plus a 10-deep one for range errors.
module tb_reg_bank_sel;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_req, rd_valid, sel_err;
  logic [3:0]  wr_sel, rd_sel_a, rd_sel_b;
  logic [1:0]  wr_mode;
  logic [15:0] wr_data, rd_data_a, rd_data_b;

  logic        t_rst, t_wr_en, t_rd_req, t_rd_valid, t_sel_err;
  logic [3:0]  t_wr_sel, t_rd_sel_a, t_rd_sel_b;
  logic [1:0]  t_wr_mode;
  logic [15:0] t_wr_data, t_rd_data_a, t_rd_data_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_bank_sel #(.DATA_W(16), .NUM_REGS(16), .RESET_VAL(16'h0000)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_mode(wr_mode),
    .wr_data(wr_data), .rd_req(rd_req), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .sel_err(sel_err)
  );

  reg_bank_sel #(.DATA_W(16), .NUM_REGS(10), .RESET_VAL(16'h0000)) dut10 (
    .clk(clk), .rst(t_rst), .wr_en(t_wr_en), .wr_sel(t_wr_sel), .wr_mode(t_wr_mode),
    .wr_data(t_wr_data), .rd_req(t_rd_req), .rd_sel_a(t_rd_sel_a), .rd_sel_b(t_rd_sel_b),
    .rd_valid(t_rd_valid), .rd_data_a(t_rd_data_a), .rd_data_b(t_rd_data_b), .sel_err(t_sel_err)
  );

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [3:0] s, input logic [1:0] m, input logic [15:0] d);
    wr_en = 1'b1; wr_sel = s; wr_mode = m; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] b);
    rd_req = 1'b1; rd_sel_a = a; rd_sel_b = b;
    step();
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; t_rst = 1'b1;
    step(); step();
    rst = 1'b0; t_rst = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data_a !== 16'h0) begin errors++; $display("[TB] FAIL reset_data_a: got %h expected 0000", rd_data_a); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_sel_err: got %b expected 0", sel_err); end
    do_read(4'd0, 4'd15);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_read_valid: got %b expected 1", rd_valid); end
    checks++; if (rd_data_a !== 16'h0) begin errors++; $display("[TB] FAIL first_read_a: got %h expected 0000", rd_data_a); end
    checks++; if (rd_data_b !== 16'h0) begin errors++; $display("[TB] FAIL first_read_b: got %h expected 0000", rd_data_b); end
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL valid_pulse: got %b expected 0", rd_valid); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("[TB] FAIL inrange_no_err: got %b expected 0", sel_err); end
  endtask

  task automatic test_byte_lanes();
    do_write(4'd3, 2'b00, 16'h1234);
    do_read(4'd3, 4'd3);
    checks++; if (rd_data_a !== 16'h1234) begin errors++; $display("[TB] FAIL full_write: got %h expected 1234", rd_data_a); end
    do_write(4'd3, 2'b01, 16'h00AB);
    do_read(4'd3, 4'd0);
    checks++; if (rd_data_a !== 16'h12AB) begin errors++; $display("[TB] FAIL low_lane: got %h expected 12AB", rd_data_a); end
    do_write(4'd3, 2'b10, 16'h00CD);
    do_read(4'd3, 4'd3);
    checks++; if (rd_data_a !== 16'hCDAB) begin errors++; $display("[TB] FAIL high_lane_a: got %h expected CDAB", rd_data_a); end
    checks++; if (rd_data_b !== 16'hCDAB) begin errors++; $display("[TB] FAIL high_lane_b: got %h expected CDAB", rd_data_b); end
    do_write(4'd3, 2'b11, 16'hFFFF);
    do_read(4'd3, 4'd4);
    checks++; if (rd_data_a !== 16'hCDAB) begin errors++; $display("[TB] FAIL nop_mode: got %h expected CDAB", rd_data_a); end
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data_a !== 16'hCDAB) begin errors++; $display("[TB] FAIL hold_data: got %h expected CDAB", rd_data_a); end
  endtask

  task automatic test_bypass();
    logic [15:0] exp_full, exp_half;
`ifdef REG_BANK_BYPASS_EN
    exp_full = 16'hBEEF; exp_half = 16'hBE12;
`else
    exp_full = 16'h0000; exp_half = 16'hBEEF;
`endif
    rd_req = 1'b1; rd_sel_a = 4'd5; rd_sel_b = 4'd6;
    do_write(4'd5, 2'b00, 16'hBEEF);
    rd_req = 1'b0;
    checks++; if (rd_data_a !== exp_full) begin errors++; $display("[TB] FAIL same_cycle_full: got %h expected %h", rd_data_a, exp_full); end
    do_read(4'd5, 4'd5);
    checks++; if (rd_data_b !== 16'hBEEF) begin errors++; $display("[TB] FAIL after_write: got %h expected BEEF", rd_data_b); end
    rd_req = 1'b1; rd_sel_a = 4'd0; rd_sel_b = 4'd5;
    do_write(4'd5, 2'b01, 16'h0012);
    rd_req = 1'b0;
    checks++; if (rd_data_b !== exp_half) begin errors++; $display("[TB] FAIL same_cycle_half: got %h expected %h", rd_data_b, exp_half); end
    do_read(4'd5, 4'd1);
    checks++; if (rd_data_a !== 16'hBE12) begin errors++; $display("[TB] FAIL after_half: got %h expected BE12", rd_data_a); end
  endtask

  task automatic test_out_of_range();
    t_wr_en = 1'b0; t_rd_req = 1'b0; t_wr_sel = 4'd15; t_rd_sel_a = 4'd15; t_rd_sel_b = 4'd12;
    step();
    checks++; if (t_sel_err !== 1'b0) begin errors++; $display("[TB] FAIL no_strobe_no_err: got %b expected 0", t_sel_err); end
    t_wr_en = 1'b1; t_wr_sel = 4'd9; t_wr_mode = 2'b00; t_wr_data = 16'h0909;
    step();
    t_wr_sel = 4'd12; t_wr_data = 16'hFFFF;
    step();
    t_wr_en = 1'b0;
    checks++; if (t_sel_err !== 1'b1) begin errors++; $display("[TB] FAIL oor_write_err: got %b expected 1", t_sel_err); end
    t_rd_req = 1'b1; t_rd_sel_a = 4'd12; t_rd_sel_b = 4'd9;
    step();
    t_rd_req = 1'b0;
    checks++; if (t_rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL oor_read_valid: got %b expected 1", t_rd_valid); end
    checks++; if (t_rd_data_a !== 16'h0) begin errors++; $display("[TB] FAIL oor_read_a: got %h expected 0000", t_rd_data_a); end
    checks++; if (t_rd_data_b !== 16'h0909) begin errors++; $display("[TB] FAIL r9_unchanged: got %h expected 0909", t_rd_data_b); end
    step(); step(); step();
    checks++; if (t_sel_err !== 1'b1) begin errors++; $display("[TB] FAIL sticky_err: got %b expected 1", t_sel_err); end
    t_rst = 1'b1;
    step();
    t_rst = 1'b0;
    checks++; if (t_sel_err !== 1'b0) begin errors++; $display("[TB] FAIL err_cleared: got %b expected 0", t_sel_err); end
    t_rd_req = 1'b1; t_rd_sel_a = 4'd0; t_rd_sel_b = 4'd10;
    step();
    t_rd_req = 1'b0;
    checks++; if (t_sel_err !== 1'b1) begin errors++; $display("[TB] FAIL oor_port_b_err: got %b expected 1", t_sel_err); end
    checks++; if (t_rd_data_b !== 16'h0) begin errors++; $display("[TB] FAIL oor_port_b_data: got %h expected 0000", t_rd_data_b); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_write(4'(i), 2'b00, 16'(i + 1));
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1; rd_sel_a = 4'(i); rd_sel_b = 4'(3 - i);
      step();
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", i, rd_valid); end
      checks++; if (rd_data_a !== 16'(i + 1)) begin errors++; $display("[TB] FAIL b2b_a[%0d]: got %h expected %h", i, rd_data_a, 16'(i + 1)); end
      checks++; if (rd_data_b !== 16'(4 - i)) begin errors++; $display("[TB] FAIL b2b_b[%0d]: got %h expected %h", i, rd_data_b, 16'(4 - i)); end
    end
    rd_req = 1'b0;
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end: got %b expected 0", rd_valid); end
    for (int i = 0; i < 3; i++) begin
      rd_req = 1'b1; rd_sel_a = 4'(i); rd_sel_b = 4'(i);
      rst = (i == 2);
      step();
    end
    rst = 1'b0; rd_req = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data_a !== 16'h0) begin errors++; $display("[TB] FAIL rst_mid_a: got %h expected 0000", rd_data_a); end
    checks++; if (rd_data_b !== 16'h0) begin errors++; $display("[TB] FAIL rst_mid_b: got %h expected 0000", rd_data_b); end
    do_read(4'd1, 4'd3);
    checks++; if (rd_data_a !== 16'h0) begin errors++; $display("[TB] FAIL regs_reset: got %h expected 0000", rd_data_a); end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_mode = 2'b00; wr_data = '0;
    rd_req = 1'b0; rd_sel_a = '0; rd_sel_b = '0;
    t_rst = 1'b1; t_wr_en = 1'b0; t_wr_sel = '0; t_wr_mode = 2'b00; t_wr_data = '0;
    t_rd_req = 1'b0; t_rd_sel_a = '0; t_rd_sel_b = '0;
    step();
    test_reset();
    test_byte_lanes();
    test_bypass();
    test_out_of_range();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
